// File: rtl/intc_pkg.sv
// Shared constants for the interrupt controller: register offsets, ID width
// and the byte-enable expansion helper.
package intc_pkg;

    localparam int unsigned INTC_ADDR_OFFSET = 10;
    localparam int unsigned INTC_ID_W        = 5;
    localparam int unsigned CTRL_TIE_BIT     = 0;

    localparam logic [INTC_ADDR_OFFSET-1:0] INTC_PENDING = 10'h000;
    localparam logic [INTC_ADDR_OFFSET-1:0] INTC_ENABLE  = 10'h004;
    localparam logic [INTC_ADDR_OFFSET-1:0] INTC_EDGE    = 10'h008;
    localparam logic [INTC_ADDR_OFFSET-1:0] INTC_CLAIM   = 10'h00C;
    localparam logic [INTC_ADDR_OFFSET-1:0] INTC_CTRL    = 10'h010;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/intc_src_cell.sv
// One interrupt source: 2-flop synchroniser plus history flop, edge/level
// pending capture and the in-service bit used for claim/complete masking.
module intc_src_cell (
    input  logic ck_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic edge_mode_i,
    input  logic clear_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pending_o,
    output logic in_service_o
);

    logic s1_q, s2_q, s3_q;
    logic pending_q, pending_d;
    logic in_service_q, in_service_d;

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            s1_q         <= src_i;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    // In edge mode a fresh rising edge beats a same-cycle W1C or claim clear.
    always_comb begin
        pending_d    = pending_q;
        in_service_d = in_service_q;
        if (edge_mode_i) begin
            if (clear_i || claim_i) begin
                pending_d = 1'b0;
            end
            if (s2_q && !s3_q) begin
                pending_d = 1'b1;
            end
        end else begin
            pending_d = s2_q;
        end
        if (complete_i) begin
            in_service_d = 1'b0;
        end
        if (claim_i) begin
            in_service_d = 1'b1;
        end
    end

    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: register file, same-cycle bus decode,
// lowest-ID-first claim encoder and registered timer/external IRQ outputs.
module intr_ctrl
    import intc_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned NumSrc       = 8
) (
    input  logic                    ck_i,
    input  logic                    rst_ni,
    input  logic                    intc_req_i,
    input  logic [AddressWidth-1:0] intc_addr_i,
    input  logic                    intc_we_i,
    input  logic [DataWidth/8-1:0]  intc_be_i,
    input  logic [DataWidth-1:0]    intc_wdata_i,
    output logic                    intc_rvalid_o,
    output logic [DataWidth-1:0]    intc_rdata_o,
    output logic                    intc_err_o,
    input  logic                    timer_intr_i,
    input  logic [NumSrc-1:0]       src_i,
    output logic                    irq_timer_o,
    output logic                    irq_external_o
);

    logic [INTC_ADDR_OFFSET-1:0] offset;
    logic [DataWidth-1:0]        wmask;
    logic [NumSrc-1:0]           wmask_src, wdata_src;

    logic [NumSrc-1:0] enable_q, enable_d;
    logic [NumSrc-1:0] edge_q, edge_d;
    logic              tie_q, tie_d;
    logic              irq_timer_q, irq_ext_q;

    logic [NumSrc-1:0] pending, in_service, claimable;
    logic [NumSrc-1:0] w1c, claim_oh, complete_oh;
    logic [INTC_ID_W-1:0] claim_id;

    logic wr_pending, wr_enable, wr_edge, wr_ctrl, wr_claim, rd_claim;
    logic [DataWidth-1:0] rdata_c;
    logic err_c;

    assign offset    = intc_addr_i[INTC_ADDR_OFFSET-1:0];
    assign wmask     = DataWidth'(be_to_mask(4'(intc_be_i)));
    assign wmask_src = wmask[NumSrc-1:0];
    assign wdata_src = intc_wdata_i[NumSrc-1:0];

    // Upper address bits are decoded by the bus fabric; upper wdata bits map to nothing.
    logic unused_bits;
    assign unused_bits = ^{intc_addr_i, intc_wdata_i, wmask};

    assign claimable = pending & enable_q & ~in_service;

    // Lowest-numbered claimable source wins.
    always_comb begin
        claim_id = '0;
        for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
            if (claimable[i]) begin
                claim_id = INTC_ID_W'(i + 1);
            end
        end
    end

    always_comb begin
        rdata_c    = '0;
        err_c      = 1'b0;
        wr_pending = 1'b0;
        wr_enable  = 1'b0;
        wr_edge    = 1'b0;
        wr_ctrl    = 1'b0;
        wr_claim   = 1'b0;
        rd_claim   = 1'b0;
        if (intc_req_i) begin
            case (offset)
                INTC_PENDING: begin
                    rdata_c    = DataWidth'(pending);
                    wr_pending = intc_we_i;
                end
                INTC_ENABLE: begin
                    rdata_c   = DataWidth'(enable_q);
                    wr_enable = intc_we_i;
                end
                INTC_EDGE: begin
                    rdata_c = DataWidth'(edge_q);
                    wr_edge = intc_we_i;
                end
                INTC_CLAIM: begin
                    rdata_c  = intc_we_i ? '0 : DataWidth'(claim_id);
                    wr_claim = intc_we_i;
                    rd_claim = !intc_we_i;
                end
                INTC_CTRL: begin
                    rdata_c = DataWidth'(tie_q);
                    wr_ctrl = intc_we_i;
                end
                default: begin
                    err_c = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        enable_d = enable_q;
        edge_d   = edge_q;
        tie_d    = tie_q;
        if (wr_enable) begin
            enable_d = (enable_q & ~wmask_src) | (wdata_src & wmask_src);
        end
        if (wr_edge) begin
            edge_d = (edge_q & ~wmask_src) | (wdata_src & wmask_src);
        end
        if (wr_ctrl && wmask[CTRL_TIE_BIT]) begin
            tie_d = intc_wdata_i[CTRL_TIE_BIT];
        end
    end

    // Per-source strobes; a complete for an ID outside 1..NumSrc matches nothing.
    always_comb begin
        w1c         = wr_pending ? (wdata_src & wmask_src) : '0;
        claim_oh    = '0;
        complete_oh = '0;
        for (int i = 0; i < int'(NumSrc); i++) begin
            claim_oh[i]    = rd_claim && (claim_id == INTC_ID_W'(i + 1));
            complete_oh[i] = wr_claim && intc_be_i[0] && (intc_wdata_i[7:0] == 8'(i + 1));
        end
    end

    always_ff @(posedge ck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enable_q    <= '0;
            edge_q      <= '0;
            tie_q       <= 1'b0;
            irq_timer_q <= 1'b0;
            irq_ext_q   <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            edge_q      <= edge_d;
            tie_q       <= tie_d;
            irq_timer_q <= timer_intr_i & tie_q;
            irq_ext_q   <= |claimable;
        end
    end

    for (genvar g = 0; g < int'(NumSrc); g++) begin : g_src
        intc_src_cell u_cell (
            .ck_i         (ck_i),
            .rst_ni       (rst_ni),
            .src_i        (src_i[g]),
            .edge_mode_i  (edge_q[g]),
            .clear_i      (w1c[g]),
            .claim_i      (claim_oh[g]),
            .complete_i   (complete_oh[g]),
            .pending_o    (pending[g]),
            .in_service_o (in_service[g])
        );
    end

    assign intc_rvalid_o  = intc_req_i;
    assign intc_rdata_o   = rdata_c;
    assign intc_err_o     = err_c;
    assign irq_timer_o    = irq_timer_q;
    assign irq_external_o = irq_ext_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed scoreboard bench for intr_ctrl: expectations are queued as each
// step is driven and popped when the DUT output is sampled.
module tb_intr_ctrl;
    import intc_pkg::*;

    localparam int unsigned NumSrc = 8;

    logic        ck_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        intc_req_i = 1'b0;
    logic [31:0] intc_addr_i = '0;
    logic        intc_we_i = 1'b0;
    logic [3:0]  intc_be_i = '0;
    logic [31:0] intc_wdata_i = '0;
    logic        intc_rvalid_o;
    logic [31:0] intc_rdata_o;
    logic        intc_err_o;
    logic        timer_intr_i = 1'b0;
    logic [NumSrc-1:0] src_i = '0;
    logic        irq_timer_o;
    logic        irq_external_o;

    intr_ctrl #(.DataWidth(32), .AddressWidth(32), .NumSrc(NumSrc)) dut (
        .ck_i           (ck_i),
        .rst_ni         (rst_ni),
        .intc_req_i     (intc_req_i),
        .intc_addr_i    (intc_addr_i),
        .intc_we_i      (intc_we_i),
        .intc_be_i      (intc_be_i),
        .intc_wdata_i   (intc_wdata_i),
        .intc_rvalid_o  (intc_rvalid_o),
        .intc_rdata_o   (intc_rdata_o),
        .intc_err_o     (intc_err_o),
        .timer_intr_i   (timer_intr_i),
        .src_i          (src_i),
        .irq_timer_o    (irq_timer_o),
        .irq_external_o (irq_external_o)
    );

    always #5 ck_i = ~ck_i;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic expect_sig(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push(tag, v);
        check(obs);
    endtask

    // Upper address bits are set to show that only [9:0] are decoded.
    task automatic bus_read(input logic [9:0] off, input logic [31:0] exp_data,
                            input logic exp_err, input string tag);
        push({tag, "_rdata"}, exp_data);
        push({tag, "_err"}, 32'(exp_err));
        push({tag, "_rvalid"}, 32'd1);
        @(negedge ck_i);
        intc_req_i  = 1'b1;
        intc_we_i   = 1'b0;
        intc_addr_i = 32'h4000_0000 | 32'(off);
        intc_be_i   = 4'hF;
        #1;
        check(intc_rdata_o);
        check(32'(intc_err_o));
        check(32'(intc_rvalid_o));
        @(posedge ck_i);
        #1;
        intc_req_i = 1'b0;
    endtask

    task automatic bus_write(input logic [9:0] off, input logic [31:0] data,
                             input logic [3:0] be);
        @(negedge ck_i);
        intc_req_i   = 1'b1;
        intc_we_i    = 1'b1;
        intc_addr_i  = 32'h4000_0000 | 32'(off);
        intc_be_i    = be;
        intc_wdata_i = data;
        @(posedge ck_i);
        #1;
        intc_req_i = 1'b0;
        intc_we_i  = 1'b0;
    endtask

    task automatic pulse_src(input int idx);
        @(negedge ck_i);
        src_i[idx] = 1'b1;
        @(negedge ck_i);
        src_i[idx] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge ck_i);
        #1;
    endtask

    initial begin
        // Reset state with an idle bus
        #2;
        expect_sig("rst_irq_timer", 32'(irq_timer_o), 32'd0);
        expect_sig("rst_irq_ext", 32'(irq_external_o), 32'd0);
        expect_sig("idle_rvalid", 32'(intc_rvalid_o), 32'd0);
        expect_sig("idle_rdata", intc_rdata_o, 32'd0);
        expect_sig("idle_err", 32'(intc_err_o), 32'd0);
        repeat (2) @(negedge ck_i);
        rst_ni = 1'b1;

        // Edge source: latency, claim, masking while in service, complete
        bus_write(INTC_EDGE, 32'h01, 4'hF);
        bus_write(INTC_ENABLE, 32'h01, 4'hF);
        pulse_src(0);
        @(posedge ck_i);
        bus_read(INTC_PENDING, 32'h00, 1'b0, "edge_pend_e1");
        expect_sig("edge_irq_e2", 32'(irq_external_o), 32'd0);
        bus_read(INTC_PENDING, 32'h01, 1'b0, "edge_pend_e2");
        expect_sig("edge_irq_e3", 32'(irq_external_o), 32'd1);
        bus_read(INTC_CLAIM, 32'd1, 1'b0, "edge_claim");
        expect_sig("edge_irq_claim_edge", 32'(irq_external_o), 32'd1);
        bus_read(INTC_PENDING, 32'h00, 1'b0, "edge_pend_after_claim");
        expect_sig("edge_irq_dropped", 32'(irq_external_o), 32'd0);
        pulse_src(0);
        cycles(3);
        expect_sig("edge_irq_masked", 32'(irq_external_o), 32'd0);
        bus_read(INTC_PENDING, 32'h01, 1'b0, "edge_repend");
        bus_read(INTC_CLAIM, 32'd0, 1'b0, "edge_claim_masked");
        bus_write(INTC_CLAIM, 32'd1, 4'b0010);
        bus_read(INTC_CLAIM, 32'd0, 1'b0, "complete_be0_clear");
        bus_write(INTC_CLAIM, 32'd9, 4'hF);
        bus_write(INTC_CLAIM, 32'd1, 4'hF);
        expect_sig("irq_complete_edge", 32'(irq_external_o), 32'd0);
        cycles(1);
        expect_sig("irq_after_complete", 32'(irq_external_o), 32'd1);
        bus_read(INTC_CLAIM, 32'd1, 1'b0, "edge_reclaim");
        bus_write(INTC_CLAIM, 32'd1, 4'hF);

        // Level sources: priority, masking, re-claim after complete
        bus_write(INTC_EDGE, 32'h00, 4'hF);
        bus_write(INTC_ENABLE, 32'h0C, 4'hF);
        @(negedge ck_i);
        src_i[2] = 1'b1;
        src_i[3] = 1'b1;
        cycles(4);
        expect_sig("lvl_irq", 32'(irq_external_o), 32'd1);
        bus_read(INTC_PENDING, 32'h0C, 1'b0, "lvl_pend");
        bus_read(INTC_CLAIM, 32'd3, 1'b0, "prio_claim3");
        bus_read(INTC_CLAIM, 32'd4, 1'b0, "prio_claim4");
        bus_read(INTC_CLAIM, 32'd0, 1'b0, "prio_claim0");
        expect_sig("lvl_irq_all_claimed", 32'(irq_external_o), 32'd0);
        bus_read(INTC_PENDING, 32'h0C, 1'b0, "lvl_pend_kept");
        bus_write(INTC_CLAIM, 32'd3, 4'hF);
        bus_read(INTC_CLAIM, 32'd3, 1'b0, "lvl_reclaim3");
        bus_write(INTC_CLAIM, 32'd3, 4'hF);
        bus_write(INTC_CLAIM, 32'd4, 4'hF);
        @(negedge ck_i);
        src_i[2] = 1'b0;
        src_i[3] = 1'b0;
        cycles(3);
        bus_read(INTC_PENDING, 32'h00, 1'b0, "lvl_pend_gone");

        // W1C colliding with a new edge; W1C ignored on level bits
        bus_write(INTC_EDGE, 32'h02, 4'hF);
        pulse_src(1);
        @(posedge ck_i);
        bus_write(INTC_PENDING, 32'h02, 4'hF);
        bus_read(INTC_PENDING, 32'h02, 1'b0, "w1c_vs_set");
        bus_write(INTC_PENDING, 32'h02, 4'hF);
        bus_read(INTC_PENDING, 32'h00, 1'b0, "w1c_clears");
        @(negedge ck_i);
        src_i[3] = 1'b1;
        cycles(3);
        bus_write(INTC_PENDING, 32'h08, 4'hF);
        bus_read(INTC_PENDING, 32'h08, 1'b0, "w1c_level_ignored");
        @(negedge ck_i);
        src_i[3] = 1'b0;
        cycles(3);
        bus_read(INTC_PENDING, 32'h00, 1'b0, "level_follows_src");

        // Timer path
        @(negedge ck_i);
        timer_intr_i = 1'b1;
        cycles(2);
        expect_sig("timer_tie0", 32'(irq_timer_o), 32'd0);
        bus_write(INTC_CTRL, 32'h1, 4'hF);
        expect_sig("timer_tie_edge", 32'(irq_timer_o), 32'd0);
        cycles(1);
        expect_sig("timer_on", 32'(irq_timer_o), 32'd1);
        bus_read(INTC_CTRL, 32'h1, 1'b0, "ctrl_read");
        @(negedge ck_i);
        timer_intr_i = 1'b0;
        cycles(1);
        expect_sig("timer_off", 32'(irq_timer_o), 32'd0);

        // Bus errors, byte enables, unimplemented bits
        bus_read(10'h014, 32'h0, 1'b1, "bad_off_rd");
        bus_read(10'h002, 32'h0, 1'b1, "misaligned_rd");
        bus_write(INTC_ENABLE, 32'h00, 4'hF);
        push("bad_off_wr_err", 32'd1);
        @(negedge ck_i);
        intc_req_i   = 1'b1;
        intc_we_i    = 1'b1;
        intc_addr_i  = 32'h014;
        intc_be_i    = 4'hF;
        intc_wdata_i = 32'hFF;
        #1;
        check(32'(intc_err_o));
        @(posedge ck_i);
        #1;
        intc_req_i = 1'b0;
        intc_we_i  = 1'b0;
        bus_read(INTC_ENABLE, 32'h00, 1'b0, "bad_wr_no_effect");
        bus_write(INTC_ENABLE, 32'hFF, 4'b0010);
        bus_read(INTC_ENABLE, 32'h00, 1'b0, "be_byte1_only");
        bus_write(INTC_ENABLE, 32'hFF, 4'b0001);
        bus_read(INTC_ENABLE, 32'hFF, 1'b0, "be_byte0");
        bus_write(INTC_EDGE, 32'hFFFF_FFFF, 4'hF);
        bus_read(INTC_EDGE, 32'h0000_00FF, 1'b0, "edge_unimpl_bits");
        bus_write(INTC_EDGE, 32'h04, 4'hF);

        // Reset mid-operation with PENDING=0x05 and source 1 in service
        @(negedge ck_i);
        src_i[0] = 1'b1;
        pulse_src(2);
        cycles(3);
        bus_read(INTC_PENDING, 32'h05, 1'b0, "pre_rst_pend");
        bus_read(INTC_CLAIM, 32'd1, 1'b0, "pre_rst_claim");
        bus_read(INTC_PENDING, 32'h05, 1'b0, "pre_rst_pend_kept");
        @(negedge ck_i);
        timer_intr_i = 1'b1;
        cycles(2);
        expect_sig("pre_rst_irq_timer", 32'(irq_timer_o), 32'd1);
        expect_sig("pre_rst_irq_ext", 32'(irq_external_o), 32'd1);
        @(negedge ck_i);
        rst_ni = 1'b0;
        #1;
        expect_sig("mid_rst_irq_timer", 32'(irq_timer_o), 32'd0);
        expect_sig("mid_rst_irq_ext", 32'(irq_external_o), 32'd0);
        src_i        = '0;
        timer_intr_i = 1'b0;
        repeat (2) @(negedge ck_i);
        rst_ni = 1'b1;
        bus_read(INTC_PENDING, 32'h00, 1'b0, "post_rst_pend");
        bus_read(INTC_ENABLE, 32'h00, 1'b0, "post_rst_enable");
        bus_read(INTC_CLAIM, 32'd0, 1'b0, "post_rst_claim");
        bus_read(INTC_CTRL, 32'h0, 1'b0, "post_rst_ctrl");
        expect_sig("post_rst_irq_ext", 32'(irq_external_o), 32'd0);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Memory-mapped interrupt controller sitting directly downstream of the machine timer.
- Collects the timer interrupt level and NumSrc external interrupt lines, then latches, masks and prioritises them.
- Presents a timer IRQ, an external IRQ and a claim/complete interface to the core over the same simple same-cycle bus slave protocol used by the other peripherals.
- Decoded by the bus in its own 1 kB window.

Parameters:
DataWidth, 32, bus data width (must be 32)
AddressWidth, 32, bus address width
NumSrc, 8, number of external sources (1..31); IDs 1..NumSrc, ID 0 = none

Ports:
ck_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
intc_req_i  in  1  bus request (window already decoded)
intc_addr_i  in  AddressWidth  byte address; only [9:0] decoded
intc_we_i  in  1  write enable
intc_be_i  in  DataWidth/8  byte enables
intc_wdata_i  in  DataWidth  write data
intc_rvalid_o  out  1  response valid, same cycle as request
intc_rdata_o  out  DataWidth  read data, same cycle
intc_err_o  out  1  access error, same cycle
timer_intr_i  in  1  level interrupt from timer (already in ck_i domain)
src_i  in  NumSrc  asynchronous external interrupt lines
irq_timer_o  out  1  timer_intr_i AND CTRL.TIE, registered
irq_external_o  out  1  any pending&enabled&~in-service, registered

Behaviour:
- Clock and reset: one clock ck_i; reset asynchronous, active-low on rst_ni.
- Reset values: all outputs 0; all registers, synchronisers and in-service bits 0.
- Bus timing: intc_rvalid_o = intc_req_i combinationally; rdata/err are 0 when no request.
- Bus side effects: take place at the rising edge that ends the request cycle.
- Register map (offset = addr[9:0]):
  - 0x00 PENDING: RO value; write = W1C on edge-mode bits only; level bits ignore writes.
  - 0x04 ENABLE: RW; bits [NumSrc-1:0].
  - 0x08 EDGE: RW; 1 = rising-edge source, 0 = level.
  - 0x0C CLAIM: see claim/complete below.
  - 0x10 CTRL: RW; bit0 = TIE (timer IRQ enable).
- Byte enables: RW registers honour intc_be_i per byte. Unimplemented bits read 0 and ignore writes.
- Errors: any other offset reads 0 with intc_err_o=1; writes to it have no effect and also raise err.
- Synchroniser: each src_i bit passes through 2 flops (s1, s2) plus a history flop s3.
- Edge-mode pending: set when s2 & ~s3. Cleared by W1C or by claim. Set wins over a same-cycle clear.
- Level-mode pending: registered copy of s2. Claim does not clear it.
- Latency: src_i high before edge E0 gives PENDING visible after E2 and irq_external_o high after E3, in both modes.
- Claim read:
  - Returns the lowest-numbered ID with pending & enable & ~in_service, or 0 if none.
  - On the same edge, sets in_service[ID] and, if the source is edge mode, clears its pending bit.
  - A read returning 0 has no side effect.
- Complete write:
  - A write to CLAIM with wdata[7:0]=ID clears in_service[ID].
  - ID 0, ID > NumSrc, or a source not in service: ignored, no error.
  - intc_be_i[0] must be set, otherwise ignored.
- Masking: an in-service source is masked from irq_external_o and from claim until completed, even if it re-pends.
- Enable changes: clearing an ENABLE bit does not clear pending or in_service.
- irq_external_o: registered OR-reduction; deasserts the cycle after the last claimable source is claimed.
- irq_timer_o: registered (timer_intr_i & TIE); one cycle of latency.
- Reset mid-operation: every state returns to reset immediately; synchronisers are flushed, so an in-flight edge is lost.

Decomposition:
- Shared package intc_pkg:
  - Register offsets INTC_PENDING/ENABLE/EDGE/CLAIM/CTRL.
  - INTC_ADDR_OFFSET=10.
  - CTRL_TIE_BIT=0.
  - INTC_ID_W=5.
- One natural sub-module, intc_src_cell: per-source synchroniser, edge detect, pending and in-service flops; instantiated NumSrc times via generate.
- Top level holds the register file, priority encoder and bus decode.

Test Plan:
- Reset: assert rst_ni=0 mid-run with PENDING=0x05 and in_service set -> all outputs 0; reads of PENDING, ENABLE and CLAIM return 0 after release.
- Edge source: EDGE=0x01, ENABLE=0x01, pulse src_i[0] for 1 cycle -> PENDING=0x01 after E2, irq_external_o=1 after E3. Claim read returns 1, PENDING=0, and irq drops the next cycle. Writing 1 to CLAIM clears in-service.
- Priority and masking: ENABLE=0x0C, level src_i[2] and src_i[3] both high -> claim returns 3, then 4, then 0. Complete 3 while src_i[2] is still high -> next claim returns 3 again.
- Simultaneous events: W1C of PENDING bit 1 in the same cycle a new edge on src 1 sets it -> PENDING bit 1 remains 1.
- Timer path: TIE=0, timer_intr_i=1 -> irq_timer_o=0. Write CTRL=0x1 -> irq_timer_o=1 one cycle later. Drop timer_intr_i -> irq_timer_o=0 one cycle later.
- Bus errors and byte enables: read 0x14 -> rdata=0, err=1, rvalid=1. Write ENABLE=0xFF with be=0b0010 -> ENABLE unchanged (bits 7:0 live only in byte 0). Write with be=0b0001 -> ENABLE=0xFF for NumSrc=8.
